// File: rtl/rot_vec_pkg.sv
// Shared types for the rotation vector serializer.
// FSM state, default element width and beat index width helper.
package rot_vec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rv_state_e;

  localparam int BW_TRIG_DEF = 9;

  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/rot_vec_slice_mux.sv
// One channel of the serializer: picks SLICE elements of the
// latched N_ELEM-element vector according to the beat index.
module rot_vec_slice_mux #(
  parameter int BW     = 9,
  parameter int N_ELEM = 512,
  parameter int SLICE  = 128,
  parameter int BEAT_W = 2
) (
  input  logic [N_ELEM*BW-1:0] data,
  input  logic [BEAT_W-1:0]    beat,
  output logic [SLICE*BW-1:0]  slice
);

  localparam int BEATS = N_ELEM / SLICE;
  localparam int SL_W  = SLICE * BW;

  always_comb begin
    slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        slice = data[b*SL_W +: SL_W];
      end
    end
  end

endmodule

// File: rtl/rotation_vec_serializer.sv
// Serializes N_CH latched trig vectors into SLICE-wide beats.
// Define ROT_VEC_DOUBLE_BUF_EN to add a shadow buffer (zero-bubble).
module rotation_vec_serializer
  import rot_vec_pkg::*;
#(
  parameter int BW_TRIGONOMETRY = BW_TRIG_DEF,
  parameter int N_ELEM          = 512,
  parameter int SLICE           = 128,
  parameter int N_CH            = 4,
  localparam int BEATS  = (SLICE > 0) ? N_ELEM / SLICE : 1,
  localparam int BEAT_W = beat_w(BEATS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_CH*N_ELEM*BW_TRIGONOMETRY-1:0] in_vec,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_CH*SLICE*BW_TRIGONOMETRY-1:0]  out_vec,
  output logic [BEAT_W-1:0]                   out_beat,
  output logic                                out_last,
  output logic                                busy
);

  localparam int CH_W  = N_ELEM * BW_TRIGONOMETRY;
  localparam int SL_W  = SLICE * BW_TRIGONOMETRY;
  localparam int VEC_W = N_CH * CH_W;
  localparam int OUT_W = N_CH * SL_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (SLICE == 0 || N_CH == 0) begin : g_bad_zero
    $error("rotation_vec_serializer: SLICE and N_CH must be nonzero");
  end else if (N_ELEM % SLICE != 0) begin : g_bad_div
    $error("rotation_vec_serializer: N_ELEM must be a multiple of SLICE");
  end

  rv_state_e           state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [VEC_W-1:0]    main_q;
  logic                load_main;
  logic                drain;
  logic                last;
  logic [OUT_W-1:0]    mux_out;

`ifdef ROT_VEC_DOUBLE_BUF_EN
  logic [VEC_W-1:0]    shadow_q;
  logic                shadow_full_q, shadow_full_d;
  logic                load_shadow;
  logic                promote;
`endif

  assign drain = (state_q == DRAIN);
  assign last  = (beat_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    load_main = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef ROT_VEC_DOUBLE_BUF_EN
    load_shadow   = 1'b0;
    promote       = 1'b0;
    shadow_full_d = shadow_full_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_main = 1'b1;
          beat_d    = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
`ifdef ROT_VEC_DOUBLE_BUF_EN
        in_ready = !shadow_full_q;
`endif
        if (out_ready && last) begin
          beat_d = '0;
`ifdef ROT_VEC_DOUBLE_BUF_EN
          // pending vector keeps the drain going with no bubble
          if (shadow_full_q) begin
            promote       = 1'b1;
            shadow_full_d = 1'b0;
          end else if (in_valid) begin
            load_main = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          if (out_ready) begin
            beat_d = beat_q + 1'b1;
          end
`ifdef ROT_VEC_DOUBLE_BUF_EN
          if (in_valid && !shadow_full_q) begin
            load_shadow   = 1'b1;
            shadow_full_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= in_vec;
`ifdef ROT_VEC_DOUBLE_BUF_EN
    end else if (promote) begin
      main_q <= shadow_q;
`endif
    end
  end

`ifdef ROT_VEC_DOUBLE_BUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      shadow_full_q <= shadow_full_d;
      if (load_shadow) begin
        shadow_q <= in_vec;
      end
    end
  end
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    rot_vec_slice_mux #(
      .BW     (BW_TRIGONOMETRY),
      .N_ELEM (N_ELEM),
      .SLICE  (SLICE),
      .BEAT_W (BEAT_W)
    ) u_mux (
      .data  (main_q[c*CH_W +: CH_W]),
      .beat  (beat_q),
      .slice (mux_out[c*SL_W +: SL_W])
    );
  end

  assign out_vec  = drain ? mux_out : '0;
  assign out_beat = drain ? beat_q : '0;
  assign out_last = drain && last;
  assign busy     = drain;

endmodule

// File: tb/tb_rotation_vec_serializer.sv
// Directed bench for rotation_vec_serializer (default and 8/8/1 builds).
module tb_rotation_vec_serializer;

  localparam int BW    = 9;
  localparam int NE    = 512;
  localparam int SL    = 128;
  localparam int NC    = 4;
  localparam int VEC_W = NC * NE * BW;
  localparam int OUT_W = NC * SL * BW;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [VEC_W-1:0] in_vec    = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_vec;
  logic [1:0]       out_beat;
  logic             out_last;
  logic             busy;

  logic        s_in_valid  = 1'b0;
  logic        s_in_ready;
  logic [71:0] s_in_vec    = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [71:0] s_out_vec;
  logic [0:0]  s_out_beat;
  logic        s_out_last;
  logic        s_busy;

  always #5 clk = ~clk;

  rotation_vec_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_beat  (out_beat),
    .out_last  (out_last),
    .busy      (busy)
  );

  rotation_vec_serializer #(
    .N_ELEM (8),
    .SLICE  (8),
    .N_CH   (1)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_vec    (s_in_vec),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_vec   (s_out_vec),
    .out_beat  (s_out_beat),
    .out_last  (s_out_last),
    .busy      (s_busy)
  );

  function automatic int el(input int pat, input int c, input int i);
    case (pat)
      0:       return (c*512 + i) % 512;
      1:       return (c*101 + i*3 + 7) % 512;
      default: return (c*55 + 511 - i) % 512;
    endcase
  endfunction

  function automatic logic [VEC_W-1:0] mk_vec(input int pat);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < NE; i++)
        v[(c*NE+i)*BW +: BW] = BW'(el(pat, c, i));
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] exp_beat(input int pat, input int b);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < SL; j++)
        v[(c*SL+j)*BW +: BW] = BW'(el(pat, c, b*SL + j));
    return v;
  endfunction

  task automatic send(input int pat);
    @(negedge clk);
    in_vec   = mk_vec(pat);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_last, busy, out_beat} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {out_valid, out_last, busy, out_beat});
    end
    checks++;
    if (out_vec !== '0) begin
      failures++;
      $display("FAIL reset_vec got=%h exp=0", out_vec[63:0]);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    send(0);
    for (int b = 0; b < 4; b++) begin
      e = exp_beat(0, b);
      checks++;
      if ({out_valid, out_beat, out_last} !== {1'b1, 2'(b), b == 3}) begin
        failures++;
        $display("FAIL basic_ctl beat=%0d got=%b exp=%b", b,
                 {out_valid, out_beat, out_last}, {1'b1, 2'(b), b == 3});
      end
      checks++;
      if (out_vec !== e) begin
        failures++;
        $display("FAIL basic_vec beat=%0d got=%h exp=%h", b,
                 out_vec[63:0], e[63:0]);
      end
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (out_vec[c*SL*BW +: BW] !== BW'((c*512 + b*128) % 512)) begin
          failures++;
          $display("FAIL basic_e0 beat=%0d ch=%0d got=%0d exp=%0d", b, c,
                   out_vec[c*SL*BW +: BW], (c*512 + b*128) % 512);
        end
      end
`ifndef ROT_VEC_DOUBLE_BUF_EN
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL basic_in_ready beat=%0d got=%b exp=0", b, in_ready);
      end
`endif
      @(negedge clk);
    end
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL basic_idle got=%b exp=001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_stall();
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    send(1);
    @(negedge clk);
    out_ready = 1'b0;
    e = exp_beat(1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_beat, out_last} !== 4'b1010) begin
        failures++;
        $display("FAIL stall_ctl cyc=%0d got=%b exp=1010", k,
                 {out_valid, out_beat, out_last});
      end
      checks++;
      if (out_vec !== e) begin
        failures++;
        $display("FAIL stall_vec cyc=%0d got=%h exp=%h", k,
                 out_vec[63:0], e[63:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    e = exp_beat(1, 2);
    checks++;
    if (out_beat !== 2'd2 || out_vec !== e) begin
      failures++;
      $display("FAIL stall_release got_beat=%0d got=%h exp_beat=2 exp=%h",
               out_beat, out_vec[63:0], e[63:0]);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_end got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    send(2);
    n = 0;
    while (!(out_valid === 1'b1 && out_beat === 2'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL rmid_wait got=timeout exp=beat2");
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, busy, out_beat} !== 5'b0) begin
      failures++;
      $display("FAIL rmid_ctl got=%b exp=00000",
               {out_valid, out_last, busy, out_beat});
    end
    checks++;
    if (out_vec !== '0) begin
      failures++;
      $display("FAIL rmid_vec got=%h exp=0", out_vec[63:0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL rmid_release got=%b exp=10", {in_ready, busy});
    end
    send(0);
    e = exp_beat(0, 0);
    checks++;
    if ({out_valid, out_beat} !== 3'b100 || out_vec !== e) begin
      failures++;
      $display("FAIL rmid_restart got=%b vec=%h exp=100 vec=%h",
               {out_valid, out_beat}, out_vec[63:0], e[63:0]);
    end
    n = 0;
    while (out_valid !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL rmid_drain got=timeout exp=idle");
    end
  endtask

`ifdef ROT_VEC_DOUBLE_BUF_EN
  task automatic test_back_to_back();
    logic [OUT_W-1:0] e;
    int b;
    logic exp_rdy;
    out_ready = 1'b1;
    @(negedge clk);
    in_vec   = mk_vec(0);
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      b = k % 4;
      e = exp_beat(k < 4 ? 0 : 1, b);
      exp_rdy = !(k >= 1 && k <= 3);
      checks++;
      if ({out_valid, out_beat, out_last, in_ready} !==
          {1'b1, 2'(b), b == 3, exp_rdy}) begin
        failures++;
        $display("FAIL b2b_ctl k=%0d got=%b exp=%b", k,
                 {out_valid, out_beat, out_last, in_ready},
                 {1'b1, 2'(b), b == 3, exp_rdy});
      end
      checks++;
      if (out_vec !== e) begin
        failures++;
        $display("FAIL b2b_vec k=%0d got=%h exp=%h", k,
                 out_vec[63:0], e[63:0]);
      end
      if (k == 0) in_vec = mk_vec(1);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=001", {out_valid, busy, in_ready});
    end
  endtask
`else
  task automatic test_back_to_back();
    logic [OUT_W-1:0] e;
    logic v;
    int b;
    out_ready = 1'b1;
    @(negedge clk);
    in_vec   = mk_vec(1);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 5) in_valid = 1'b0;
      v = (k != 4 && k != 9);
      b = (k < 4) ? k : k - 5;
      checks++;
      if ({out_valid, in_ready} !== {v, !v}) begin
        failures++;
        $display("FAIL b2b_hs k=%0d got=%b exp=%b", k,
                 {out_valid, in_ready}, {v, !v});
      end
      if (v) begin
        e = exp_beat(1, b);
        checks++;
        if (out_beat !== 2'(b) || out_vec !== e) begin
          failures++;
          $display("FAIL b2b_vec k=%0d beat=%0d got=%h exp_beat=%0d exp=%h",
                   k, out_beat, out_vec[63:0], b, e[63:0]);
        end
      end
    end
  endtask
`endif

  task automatic test_single_beat();
    logic [71:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[i*9 +: 9] = 9'(i*3 + 5);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_in_vec   = e;
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    checks++;
    if ({s_out_valid, s_out_last, s_out_beat, s_busy} !== 4'b1101) begin
      failures++;
      $display("FAIL single_ctl got=%b exp=1101",
               {s_out_valid, s_out_last, s_out_beat, s_busy});
    end
    checks++;
    if (s_out_vec !== e) begin
      failures++;
      $display("FAIL single_vec got=%h exp=%h", s_out_vec, e);
    end
    @(negedge clk);
    checks++;
    if ({s_out_valid, s_out_last, s_busy, s_in_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL single_end got=%b exp=0001",
               {s_out_valid, s_out_last, s_busy, s_in_ready});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_single_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
